dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/sys_defs.sv | 17 +
 rtl/dmem_array.sv | 21 ++
 rtl/dmem_responder.sv | 97 +++++++++
 3 files changed

// File: rtl/sys_defs.sv
// Shared bus command encodings and responder FSM states for the data-memory path.
package sys_defs;

  typedef enum logic [1:0] {
    BUS_NONE    = 2'b00,
    BUS_LOAD    = 2'b01,
    BUS_STORE   = 2'b10,
    BUS_INVALID = 2'b11
  } bus_command_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } dmem_state_e;

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage: combinational read, write on the rising edge when we is high.
module dmem_array #(
  parameter int unsigned DEPTH = 1024,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one bus command, answers LATENCY cycles later
// with a single valid pulse; misaligned, out-of-range or invalid commands fault.
//   state | meaning
//   IDLE  | no command in flight, ready to accept
//   WAIT  | latency countdown running, busy asserted, new commands dropped
//   RESP  | response cycle for the captured command, may accept the next one
module dmem_responder
  import sys_defs::*;
#(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  proc2Dmem_command,
  input  logic [31:0] proc2Dmem_addr,
  input  logic [31:0] proc2mem_data,
  output logic [31:0] mem2proc_data,
  output logic        mem2proc_valid,
  output logic        mem2proc_error,
  output logic        mem2proc_busy
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [29:0] DEPTH_W  = 30'(DEPTH);
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

  dmem_state_e  state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  bus_command_e cmd_q;
  logic [31:0]  addr_q, data_q;

  logic          accept, fault, resp, we;
  logic [AW-1:0] word_idx;
  logic [31:0]   rdata;

  assign accept = (proc2Dmem_command != BUS_NONE) && (state_q == IDLE || state_q == RESP);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, RESP: begin
        if (accept) begin
          cnt_d   = CNT_LOAD;
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cmd_q   <= BUS_NONE;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        cmd_q  <= bus_command_e'(proc2Dmem_command);
        addr_q <= proc2Dmem_addr;
        data_q <= proc2mem_data;
      end
    end
  end

  assign fault = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= DEPTH_W) || (cmd_q == BUS_INVALID);

  // Outputs are masked by rst so nothing leaks out while reset is held.
  assign resp     = rst && (state_q == RESP);
  assign word_idx = fault ? '0 : addr_q[AW+1:2];
  assign we       = resp && (cmd_q == BUS_STORE) && !fault;

  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .we    (we),
    .addr  (word_idx),
    .wdata (data_q),
    .rdata (rdata)
  );

  assign mem2proc_valid = resp;
  assign mem2proc_error = resp && fault;
  assign mem2proc_busy  = rst && (state_q == WAIT);
  assign mem2proc_data  = (resp && cmd_q == BUS_LOAD && !fault) ? rdata : 32'h0;

endmodule
